// File: rtl/matmul_pkg.sv
// Shared constants and types for the matmul operand buffer and its bank RAMs.
// Host bank-select encodings and the streaming sequencer state type.
package matmul_pkg;

    localparam logic [1:0] BANK_A = 2'd0;
    localparam logic [1:0] BANK_B = 2'd1;
    localparam logic [1:0] BANK_C = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        DONE
    } seqState_t;

endpackage

// File: rtl/matbuf_bank.sv
// One N*N-word bank with one write port and two registered read ports, cleared by reset.
// With MATBUF_PARITY_EN each word carries an even-parity bit that is checked on every read.
module matbuf_bank #(
    parameter  int DW = 32,
    parameter  int N  = 4,
    localparam int AW = $clog2(N*N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re0_i,
    input  logic [AW-1:0] raddr0_i,
    output logic [DW-1:0] rdata0_o,
    input  logic          re1_i,
    input  logic [AW-1:0] raddr1_i,
    output logic [DW-1:0] rdata1_o
`ifdef MATBUF_PARITY_EN
    ,
    output logic          perr0_o,
    output logic          perr1_o
`endif
);

    localparam int DEPTH = N*N;

`ifdef MATBUF_PARITY_EN
    localparam int WW = DW + 1;

    function automatic logic [WW-1:0] encode(input logic [DW-1:0] d);
        return {^d, d};
    endfunction
`else
    localparam int WW = DW;

    function automatic logic [WW-1:0] encode(input logic [DW-1:0] d);
        return d;
    endfunction
`endif

    // Addresses past the last word only exist when N*N is not a power of two.
    function automatic logic inRange(input logic [AW-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    logic [WW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd0_q;
    logic [DW-1:0] rd1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem_q[w] <= '0;
            end
        end else if (we_i && inRange(waddr_i)) begin
            mem_q[waddr_i] <= encode(wdata_i);
        end
    end

    // Reads sample the array before this edge's write, so same-cycle reads see old data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd0_q <= '0;
            rd1_q <= '0;
        end else begin
            if (re0_i) begin
                rd0_q <= inRange(raddr0_i) ? mem_q[raddr0_i][DW-1:0] : '0;
            end
            if (re1_i) begin
                rd1_q <= inRange(raddr1_i) ? mem_q[raddr1_i][DW-1:0] : '0;
            end
        end
    end

    assign rdata0_o = rd0_q;
    assign rdata1_o = rd1_q;

`ifdef MATBUF_PARITY_EN
    logic perr0_q;
    logic perr1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perr0_q <= 1'b0;
            perr1_q <= 1'b0;
        end else begin
            perr0_q <= re0_i && inRange(raddr0_i) && (^mem_q[raddr0_i]);
            perr1_q <= re1_i && inRange(raddr1_i) && (^mem_q[raddr1_i]);
        end
    end

    assign perr0_o = perr0_q;
    assign perr1_o = perr1_q;
`endif

endmodule

// File: rtl/matmul_operand_buffer.sv
// Operand/result store for the NxN matmul accelerator: host access to banks A/B/C and an i/j/k
// sequencer streaming (A[i][k], B[k][j]) pairs. Optional word parity under MATBUF_PARITY_EN.
module matmul_operand_buffer
    import matmul_pkg::*;
#(
    parameter  int DW = 32,
    parameter  int N  = 4,
    localparam int AW = $clog2(N*N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs_i,
    input  logic          host_we_i,
    input  logic          host_re_i,
    input  logic [1:0]    host_sel_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic [DW-1:0] host_wdata_i,
    output logic [DW-1:0] host_rdata_o,
    output logic          host_rvalid_o,
    input  logic          start_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          strm_valid_o,
    input  logic          strm_ready_i,
    output logic [DW-1:0] strm_a_o,
    output logic [DW-1:0] strm_b_o,
    output logic [AW-1:0] strm_idx_o,
    output logic          strm_last_o,
    input  logic          res_we_i,
    input  logic [AW-1:0] res_addr_i,
    input  logic [DW-1:0] res_wdata_i,
    output logic          par_err_o
);

    localparam int            IW   = $clog2(N);
    localparam logic [IW-1:0] CMAX = IW'(N - 1);

    seqState_t     state_q, state_d;
    logic [IW-1:0] cntI_q, cntI_d;
    logic [IW-1:0] cntJ_q, cntJ_d;
    logic [IW-1:0] cntK_q, cntK_d;
    logic          strmValid_q, strmValid_d;
    logic [AW-1:0] strmIdx_q, strmIdx_d;
    logic          strmLast_q, strmLast_d;
    logic          fetch;

    logic          hostWe, hostRe, busy;
    logic          aWe, bWe, cWe;
    logic [AW-1:0] cWaddr;
    logic [DW-1:0] cWdata;
    logic [AW-1:0] aStrmAddr, bStrmAddr;
    logic [DW-1:0] aRd0, bRd0, cRd0, aRd1, bRd1, unusedCRd1;
    logic          rvalid_q;
    logic [1:0]    rdSel_q;

    assign hostWe = cs_i & host_we_i;
    assign hostRe = cs_i & host_re_i & ~host_we_i;
    assign busy   = (state_q == LOAD) || (state_q == STREAM);

    // Operand banks are frozen during a pass; the result bank stays writable, datapath first.
    assign aWe    = hostWe && (host_sel_i == BANK_A) && !busy;
    assign bWe    = hostWe && (host_sel_i == BANK_B) && !busy;
    assign cWe    = res_we_i || (hostWe && (host_sel_i == BANK_C));
    assign cWaddr = res_we_i ? res_addr_i  : host_addr_i;
    assign cWdata = res_we_i ? res_wdata_i : host_wdata_i;

    assign aStrmAddr = AW'(int'(cntI_d) * N + int'(cntK_d));
    assign bStrmAddr = AW'(int'(cntK_d) * N + int'(cntJ_d));

`ifdef MATBUF_PARITY_EN
    logic aPerr0, aPerr1, bPerr0, bPerr1, cPerr0, unusedCPerr1;
`endif

    matbuf_bank #(.DW(DW), .N(N)) uBankA (
        .clk      (clk),
        .reset    (reset),
        .we_i     (aWe),
        .waddr_i  (host_addr_i),
        .wdata_i  (host_wdata_i),
        .re0_i    (hostRe && (host_sel_i == BANK_A)),
        .raddr0_i (host_addr_i),
        .rdata0_o (aRd0),
        .re1_i    (fetch),
        .raddr1_i (aStrmAddr),
        .rdata1_o (aRd1)
`ifdef MATBUF_PARITY_EN
        ,
        .perr0_o  (aPerr0),
        .perr1_o  (aPerr1)
`endif
    );

    matbuf_bank #(.DW(DW), .N(N)) uBankB (
        .clk      (clk),
        .reset    (reset),
        .we_i     (bWe),
        .waddr_i  (host_addr_i),
        .wdata_i  (host_wdata_i),
        .re0_i    (hostRe && (host_sel_i == BANK_B)),
        .raddr0_i (host_addr_i),
        .rdata0_o (bRd0),
        .re1_i    (fetch),
        .raddr1_i (bStrmAddr),
        .rdata1_o (bRd1)
`ifdef MATBUF_PARITY_EN
        ,
        .perr0_o  (bPerr0),
        .perr1_o  (bPerr1)
`endif
    );

    matbuf_bank #(.DW(DW), .N(N)) uBankC (
        .clk      (clk),
        .reset    (reset),
        .we_i     (cWe),
        .waddr_i  (cWaddr),
        .wdata_i  (cWdata),
        .re0_i    (hostRe && (host_sel_i == BANK_C)),
        .raddr0_i (host_addr_i),
        .rdata0_o (cRd0),
        .re1_i    (1'b0),
        .raddr1_i ('0),
        .rdata1_o (unusedCRd1)
`ifdef MATBUF_PARITY_EN
        ,
        .perr0_o  (cPerr0),
        .perr1_o  (unusedCPerr1)
`endif
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            rdSel_q  <= BANK_A;
        end else begin
            rvalid_q <= hostRe;
            if (hostRe) begin
                rdSel_q <= host_sel_i;
            end
        end
    end

    always_comb begin
        host_rdata_o = '0;
        case (rdSel_q)
            BANK_A:  host_rdata_o = aRd0;
            BANK_B:  host_rdata_o = bRd0;
            BANK_C:  host_rdata_o = cRd0;
            default: host_rdata_o = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cntI_q      <= '0;
            cntJ_q      <= '0;
            cntK_q      <= '0;
            strmValid_q <= 1'b0;
            strmIdx_q   <= '0;
            strmLast_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cntI_q      <= cntI_d;
            cntJ_q      <= cntJ_d;
            cntK_q      <= cntK_d;
            strmValid_q <= strmValid_d;
            strmIdx_q   <= strmIdx_d;
            strmLast_q  <= strmLast_d;
        end
    end

    // Counters name the beat being presented; a fetch reads the pair at the next counter values.
    always_comb begin
        state_d     = state_q;
        cntI_d      = cntI_q;
        cntJ_d      = cntJ_q;
        cntK_d      = cntK_q;
        strmValid_d = strmValid_q;
        strmIdx_d   = strmIdx_q;
        strmLast_d  = strmLast_q;
        fetch       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cs_i && start_i) begin
                    state_d = LOAD;
                    cntI_d  = '0;
                    cntJ_d  = '0;
                    cntK_d  = '0;
                end
            end
            LOAD: begin
                state_d     = STREAM;
                strmValid_d = 1'b1;
                fetch       = 1'b1;
            end
            STREAM: begin
                if (strmValid_q && strm_ready_i) begin
                    if (cntI_q == CMAX && cntJ_q == CMAX && cntK_q == CMAX) begin
                        state_d     = DONE;
                        strmValid_d = 1'b0;
                        strmLast_d  = 1'b0;
                    end else begin
                        fetch = 1'b1;
                        if (cntK_q == CMAX) begin
                            cntK_d = '0;
                            if (cntJ_q == CMAX) begin
                                cntJ_d = '0;
                                cntI_d = cntI_q + 1'b1;
                            end else begin
                                cntJ_d = cntJ_q + 1'b1;
                            end
                        end else begin
                            cntK_d = cntK_q + 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (fetch) begin
            strmIdx_d  = AW'(int'(cntI_d) * N + int'(cntJ_d));
            strmLast_d = (cntK_d == CMAX);
        end
    end

    assign host_rvalid_o = rvalid_q;
    assign busy_o        = busy;
    assign done_o        = (state_q == DONE);
    assign strm_valid_o  = strmValid_q;
    assign strm_a_o      = aRd1;
    assign strm_b_o      = bRd1;
    assign strm_idx_o    = strmIdx_q;
    assign strm_last_o   = strmLast_q;

`ifdef MATBUF_PARITY_EN
    logic parErr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            parErr_q <= 1'b0;
        end else if (aPerr0 || aPerr1 || bPerr0 || bPerr1 || cPerr0) begin
            parErr_q <= 1'b1;
        end
    end

    assign par_err_o = parErr_q;
`else
    assign par_err_o = 1'b0;
`endif

endmodule
